// File: rtl/keypad_if.sv
// Keypad scanner/consumer bundle: row/column lines in, decoded key events out.
interface keypad_if;
  logic [2:0] i_row_n;
  logic [3:0] i_col_n;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_release;
  logic       o_key_held;
  logic       o_multi_err;

  modport slave (
    input  i_row_n,
    input  i_col_n,
    output o_key_code,
    output o_key_valid,
    output o_key_release,
    output o_key_held,
    output o_multi_err
  );

  modport master (
    output i_row_n,
    output i_col_n,
    input  o_key_code,
    input  o_key_valid,
    input  o_key_release,
    input  o_key_held,
    input  o_multi_err
  );
endinterface

// File: rtl/keypad_matrix_decoder.sv
// 3x4 keypad decoder: synchronizes the scan lines, assembles per-frame snapshots
// and debounces single-key presses and releases over whole frames.
//
// state      | meaning
// S_IDLE     | no key accepted, waiting for a single-key frame
// S_PRESS_DB | counting consecutive frames with the same single candidate
// S_PRESSED  | candidate accepted, o_key_held high
// S_RELEASE_DB | counting consecutive frames with the candidate absent
module keypad_matrix_decoder #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_PRESSED    = 2'd2,
    S_RELEASE_DB = 2'd3
  } state_t;

  logic [2:0]    r_row_s1, r_row_s2, r_row_prev;
  logic [3:0]    r_col_s1, r_col_s2;
  logic [SW-1:0] r_settle;
  logic [11:0]   r_snap;
  logic [2:0]    r_seen;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt, w_count_inc;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_release, w_release_nxt;
  logic          r_multi, w_multi_nxt;

  logic          w_row_valid;
  logic          w_row_chg;
  logic          w_sample;
  logic [1:0]    w_row_idx;
  logic [11:0]   w_snap_nxt;
  logic [2:0]    w_seen_nxt;
  logic          w_frame_done;
  logic [3:0]    w_pop;
  logic [3:0]    w_single_idx;
  logic          w_none, w_single, w_multi;
  logic          w_cand_hit, w_others;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_row_s1 <= kp.i_row_n;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= kp.i_col_n;
      r_col_s2 <= r_col_s1;
    end
  end

  always_comb begin
    w_row_valid = 1'b1;
    w_row_idx   = 2'd0;
    case (r_row_s2)
      3'b110:  w_row_idx = 2'd0;
      3'b101:  w_row_idx = 2'd1;
      3'b011:  w_row_idx = 2'd2;
      default: w_row_valid = 1'b0;
    endcase
  end

  assign w_row_chg = (r_row_s2 != r_row_prev);
  // Counter saturates at SETTLE_CYCLES so each row phase yields one sample.
  assign w_sample  = w_row_valid && !w_row_chg && (r_settle == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_prev <= '1;
      r_settle   <= '0;
    end else begin
      r_row_prev <= r_row_s2;
      if (w_row_chg || !w_row_valid)
        r_settle <= '0;
      else if (r_settle != SW'(SETTLE_CYCLES))
        r_settle <= r_settle + SW'(1);
    end
  end

  always_comb begin
    w_snap_nxt = r_snap;
    w_seen_nxt = r_seen;
    if (w_sample) begin
      w_snap_nxt[{w_row_idx, 2'b00} +: 4] = ~r_col_s2;
      w_seen_nxt[w_row_idx]               = 1'b1;
    end
  end

  assign w_frame_done = w_sample && (w_seen_nxt == 3'b111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
      r_seen <= '0;
    end else begin
      r_snap <= w_snap_nxt;
      r_seen <= w_frame_done ? 3'b000 : w_seen_nxt;
    end
  end

  // The snapshot including this cycle's sample is what gets classified.
  always_comb begin
    w_pop        = '0;
    w_single_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (w_snap_nxt[i]) begin
        w_pop        = w_pop + 4'd1;
        w_single_idx = 4'(i);
      end
    end
  end

  assign w_none     = (w_pop == 4'd0);
  assign w_single   = (w_pop == 4'd1);
  assign w_multi    = (w_pop >= 4'd2);
  assign w_cand_hit = w_snap_nxt[r_cand];
  assign w_others   = w_cand_hit ? (w_pop >= 4'd2) : !w_none;
  assign w_count_inc = r_count + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_cand    <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_release <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_cand    <= w_cand_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_release <= w_release_nxt;
      r_multi   <= w_multi_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_cand_nxt    = r_cand;
    w_code_nxt    = r_code;
    w_valid_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_multi_nxt   = 1'b0;
    if (w_frame_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_single_idx;
            if (DEBOUNCE_FRAMES == 1) begin
              w_state_nxt = S_PRESSED;
              w_code_nxt  = w_single_idx;
              w_valid_nxt = 1'b1;
              w_count_nxt = '0;
            end else begin
              w_state_nxt = S_PRESS_DB;
              w_count_nxt = CW'(1);
            end
          end else if (w_multi) begin
            w_multi_nxt = 1'b1;
          end
        end
        S_PRESS_DB: begin
          if (w_single && (w_single_idx == r_cand)) begin
            if (w_count_inc == CW'(DEBOUNCE_FRAMES)) begin
              w_state_nxt = S_PRESSED;
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_count_nxt = '0;
            end else begin
              w_count_nxt = w_count_inc;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_multi_nxt = w_multi;
          end
        end
        S_PRESSED: begin
          if (w_cand_hit) begin
            w_multi_nxt = w_others;
          end else if (DEBOUNCE_FRAMES == 1) begin
            w_state_nxt   = S_IDLE;
            w_release_nxt = 1'b1;
            w_count_nxt   = '0;
          end else begin
            w_state_nxt = S_RELEASE_DB;
            w_count_nxt = CW'(1);
          end
        end
        S_RELEASE_DB: begin
          if (w_cand_hit) begin
            w_state_nxt = S_PRESSED;
            w_count_nxt = '0;
          end else if (w_count_inc == CW'(DEBOUNCE_FRAMES)) begin
            w_state_nxt   = S_IDLE;
            w_release_nxt = 1'b1;
            w_count_nxt   = '0;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign kp.o_key_code    = r_code;
  assign kp.o_key_valid   = r_valid;
  assign kp.o_key_release = r_release;
  assign kp.o_key_held    = (r_state == S_PRESSED) || (r_state == S_RELEASE_DB);
  assign kp.o_multi_err   = r_multi;

endmodule
